// File: rtl/mem_resp_stage_pkg.sv
// Shared types for the memory-response stage: stage states, load-op and
// exception-source bit layouts.
package mem_resp_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NOREQ = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Field order gives the bit positions: first field is the MSB.
  typedef struct packed {
    logic b;
    logic bu;
    logic h;
    logic hu;
    logic w;
  } ld_op_t;

  typedef struct packed {
    logic ine;
    logic brk;
    logic sys;
    logic ale;
    logic adef;
    logic intr;
  } exc_src_t;

endpackage

// File: rtl/mem_resp_stage_load_extract.sv
// Combinational load-data extraction: selects the addressed byte/half of the
// response word and sign- or zero-extends it according to the one-hot load op.
module mem_resp_stage_load_extract
  import mem_resp_stage_pkg::*;
(
  input  logic [4:0]  load_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  ld_op_t      op;
  logic [7:0]  byte_lane [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign op = ld_op_t'(load_op);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign byte_lane[gi] = rdata[8*gi +: 8];
  end

  assign sel_byte = byte_lane[addr];
  assign sel_half = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = 32'h0;
    if (op.b) begin
      result = {{24{sel_byte[7]}}, sel_byte};
    end else if (op.bu) begin
      result = {24'h0, sel_byte};
    end else if (op.h) begin
      result = {{16{sel_half[15]}}, sel_half};
    end else if (op.hu) begin
      result = {16'h0, sel_half};
    end else if (op.w) begin
      result = rdata;
    end
  end

endmodule

// File: rtl/mem_resp_stage.sv
// Memory-response pipeline stage (EX -> MEM -> WB) with orphaned-response tracking.
// Optional forwarding outputs are built only when MEM_FWD_EN is defined.
module mem_resp_stage
  import mem_resp_stage_pkg::*;
#(
  parameter int DROP_CNT_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        from_valid,
  input  logic        from_allowin,
  output logic        to_valid,
  output logic        to_allowin,
  input  logic [31:0] from_pc,
  input  logic [31:0] alu_result_EX,
  input  logic        rf_we_EX,
  input  logic [4:0]  rf_waddr_EX,
  input  logic        res_from_mem_EX,
  input  logic [4:0]  load_op_EX,
  input  logic        req_sent_EX,
  input  logic [5:0]  exception_source_EX,
  input  logic        ertn_flush_EX,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        ex_WB,
  input  logic        flush_WB,
  output logic [31:0] PC,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [5:0]  exception_source,
  output logic        ex_MEM,
  output logic        flush_MEM,
  output logic        fwd_we,
  output logic [4:0]  fwd_waddr,
  output logic [31:0] fwd_wdata,
  output logic        fwd_load_pending
);

  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [31:0]           pc_q, pc_d;
  logic [31:0]           alu_result_q, alu_result_d;
  logic [31:0]           rdata_buf_q, rdata_buf_d;
  logic                  rf_we_q, rf_we_d;
  logic [4:0]            rf_waddr_q, rf_waddr_d;
  logic                  res_from_mem_q, res_from_mem_d;
  logic [4:0]            load_op_q, load_op_d;
  exc_src_t              exc_q, exc_d;
  logic                  ertn_q, ertn_d;

  logic        flush;
  logic        resp_hit;
  logic        ready_go;
  logic        latch;
  logic        drop_inc;
  logic        drop_dec;
  logic [31:0] load_data;
  logic [31:0] ext_result;
  logic [31:0] final_result;

  assign flush    = ex_WB | flush_WB;
  // A response belongs to this instruction only once every orphan has drained.
  assign resp_hit = (state_q == ST_WAIT) & data_sram_data_ok & (drop_cnt_q == '0);
  assign ready_go = valid_q & ((state_q == ST_DONE) | (state_q == ST_NOREQ) | resp_hit);

  assign to_allowin = ~valid_q | (ready_go & from_allowin) | flush;
  assign to_valid   = ready_go & ~flush;
  assign latch      = from_valid & to_allowin;

  // A response landing in the flush cycle is already consumed, so it is not orphaned.
  assign drop_inc = flush & (state_q == ST_WAIT) & ~resp_hit;
  assign drop_dec = data_sram_data_ok & (drop_cnt_q != '0);

  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    drop_cnt_d     = drop_cnt_q;
    pc_d           = pc_q;
    alu_result_d   = alu_result_q;
    rdata_buf_d    = rdata_buf_q;
    rf_we_d        = rf_we_q;
    rf_waddr_d     = rf_waddr_q;
    res_from_mem_d = res_from_mem_q;
    load_op_d      = load_op_q;
    exc_d          = exc_q;
    ertn_d         = ertn_q;

    if (drop_inc && !drop_dec && (drop_cnt_q != DROP_MAX)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end else if (drop_dec && !drop_inc) begin
      drop_cnt_d = drop_cnt_q - 1'b1;
    end

    if (resp_hit) begin
      rdata_buf_d = data_sram_rdata;
    end

    if (latch) begin
      valid_d        = 1'b1;
      state_d        = req_sent_EX ? ST_WAIT : ST_NOREQ;
      pc_d           = from_pc;
      alu_result_d   = alu_result_EX;
      rf_we_d        = rf_we_EX;
      rf_waddr_d     = rf_waddr_EX;
      res_from_mem_d = res_from_mem_EX;
      load_op_d      = load_op_EX;
      exc_d          = exc_src_t'(exception_source_EX);
      ertn_d         = ertn_flush_EX;
    end else if (flush || (ready_go && from_allowin)) begin
      valid_d = 1'b0;
      state_d = ST_IDLE;
    end else if (resp_hit) begin
      state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      valid_q        <= 1'b0;
      drop_cnt_q     <= '0;
      pc_q           <= 32'h0;
      alu_result_q   <= 32'h0;
      rdata_buf_q    <= 32'h0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= 5'h0;
      res_from_mem_q <= 1'b0;
      load_op_q      <= 5'h0;
      exc_q          <= '0;
      ertn_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      drop_cnt_q     <= drop_cnt_d;
      pc_q           <= pc_d;
      alu_result_q   <= alu_result_d;
      rdata_buf_q    <= rdata_buf_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      res_from_mem_q <= res_from_mem_d;
      load_op_q      <= load_op_d;
      exc_q          <= exc_d;
      ertn_q         <= ertn_d;
    end
  end

  // Outside DONE the only live response is the one on the bus this cycle.
  assign load_data = (state_q == ST_DONE) ? rdata_buf_q : data_sram_rdata;

  mem_resp_stage_load_extract u_load_extract (
    .load_op (load_op_q),
    .addr    (alu_result_q[1:0]),
    .rdata   (load_data),
    .result  (ext_result)
  );

  assign final_result     = res_from_mem_q ? ext_result : alu_result_q;
  assign PC               = pc_q;
  assign rf_we            = rf_we_q & valid_q;
  assign rf_waddr         = rf_waddr_q;
  assign rf_wdata         = final_result;
  assign exception_source = exc_q;
  assign ex_MEM           = valid_q & (exc_q != '0);
  assign flush_MEM        = valid_q & ertn_q;

`ifdef MEM_FWD_EN
  assign fwd_we           = valid_q & rf_we_q;
  assign fwd_waddr        = rf_waddr_q;
  assign fwd_wdata        = final_result;
  assign fwd_load_pending = valid_q & res_from_mem_q & ~ready_go;
`else
  assign fwd_we           = 1'b0;
  assign fwd_waddr        = 5'h0;
  assign fwd_wdata        = 32'h0;
  assign fwd_load_pending = 1'b0;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (resetn && drop_inc && !drop_dec) begin
      assert (drop_cnt_q != DROP_MAX)
        else $error("mem_resp_stage: orphaned-response counter saturated");
    end
  end
`endif

endmodule

// File: tb/tb_mem_resp_stage.sv
// Self-checking bench for mem_resp_stage: directed vectors, a cycle model of
// the stage contract, and hand-computed literal expectations.
module tb_mem_resp_stage;

  localparam logic [4:0] LDB  = 5'b10000;
  localparam logic [4:0] LDBU = 5'b01000;
  localparam logic [4:0] LDH  = 5'b00100;
  localparam logic [4:0] LDHU = 5'b00010;
  localparam logic [4:0] LDW  = 5'b00001;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        from_valid, from_allowin;
  logic        to_valid, to_allowin;
  logic [31:0] from_pc, alu_result_EX;
  logic        rf_we_EX;
  logic [4:0]  rf_waddr_EX;
  logic        res_from_mem_EX;
  logic [4:0]  load_op_EX;
  logic        req_sent_EX;
  logic [5:0]  exception_source_EX;
  logic        ertn_flush_EX;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ex_WB, flush_WB;
  logic [31:0] PC;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [5:0]  exception_source;
  logic        ex_MEM, flush_MEM;
  logic        fwd_we;
  logic [4:0]  fwd_waddr;
  logic [31:0] fwd_wdata;
  logic        fwd_load_pending;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_resp_stage #(.DROP_CNT_W(2)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .from_valid          (from_valid),
    .from_allowin        (from_allowin),
    .to_valid            (to_valid),
    .to_allowin          (to_allowin),
    .from_pc             (from_pc),
    .alu_result_EX       (alu_result_EX),
    .rf_we_EX            (rf_we_EX),
    .rf_waddr_EX         (rf_waddr_EX),
    .res_from_mem_EX     (res_from_mem_EX),
    .load_op_EX          (load_op_EX),
    .req_sent_EX         (req_sent_EX),
    .exception_source_EX (exception_source_EX),
    .ertn_flush_EX       (ertn_flush_EX),
    .data_sram_data_ok   (data_sram_data_ok),
    .data_sram_rdata     (data_sram_rdata),
    .ex_WB               (ex_WB),
    .flush_WB            (flush_WB),
    .PC                  (PC),
    .rf_we               (rf_we),
    .rf_waddr            (rf_waddr),
    .rf_wdata            (rf_wdata),
    .exception_source    (exception_source),
    .ex_MEM              (ex_MEM),
    .flush_MEM           (flush_MEM),
    .fwd_we              (fwd_we),
    .fwd_waddr           (fwd_waddr),
    .fwd_wdata           (fwd_wdata),
    .fwd_load_pending    (fwd_load_pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid = 1'b0, m_req = 1'b0, m_got = 1'b0;
  logic [31:0] m_data = '0, m_pc = '0, m_alu = '0;
  logic        m_we = 1'b0, m_mem = 1'b0, m_ertn = 1'b0;
  logic [4:0]  m_waddr = '0, m_op = '0;
  logic [5:0]  m_exc = '0;
  int          m_orph = 0;

  function automatic logic [31:0] model_load(input logic [4:0] op, input logic [1:0] a,
                                             input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * a)) & 32'hFF;
    h = (d >> (16 * a[1])) & 32'hFFFF;
    case (op)
      LDB:     return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      LDBU:    return b;
      LDH:     return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      LDHU:    return h;
      LDW:     return d;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_flush();
    return ex_WB || flush_WB;
  endfunction
  function automatic logic m_resp_now();
    return m_valid && m_req && !m_got && data_sram_data_ok && (m_orph == 0);
  endfunction
  function automatic logic m_ready();
    return m_valid && (!m_req || m_got || m_resp_now());
  endfunction
  function automatic logic exp_to_valid();
    return m_ready() && !m_flush();
  endfunction
  function automatic logic exp_allowin();
    return !m_valid || (m_ready() && from_allowin) || m_flush();
  endfunction
  function automatic logic [31:0] m_wdata();
    return m_mem ? model_load(m_op, m_alu[1:0], m_got ? m_data : data_sram_rdata) : m_alu;
  endfunction
  function automatic int m_orph_next();
    int n;
    n = m_orph;
    if (m_flush() && m_valid && m_req && !m_got && !m_resp_now()) n = n + 1;
    if (data_sram_data_ok && m_orph > 0) n = n - 1;
    return n;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid <= 1'b0;
      m_req   <= 1'b0;
      m_got   <= 1'b0;
      m_orph  <= 0;
    end else begin
      m_orph <= m_orph_next();
      if (from_valid && exp_allowin()) begin
        m_valid <= 1'b1;
        m_req   <= req_sent_EX;
        m_got   <= 1'b0;
        m_pc    <= from_pc;
        m_alu   <= alu_result_EX;
        m_we    <= rf_we_EX;
        m_waddr <= rf_waddr_EX;
        m_mem   <= res_from_mem_EX;
        m_op    <= load_op_EX;
        m_exc   <= exception_source_EX;
        m_ertn  <= ertn_flush_EX;
      end else if (m_flush() || (m_ready() && from_allowin)) begin
        m_valid <= 1'b0;
      end else if (m_resp_now()) begin
        m_got  <= 1'b1;
        m_data <= data_sram_rdata;
      end
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      check("mdl_to_valid", to_valid, exp_to_valid());
      check("mdl_to_allowin", to_allowin, exp_allowin());
      check("mdl_rf_we", rf_we, m_valid && m_we);
      check("mdl_ex_MEM", ex_MEM, m_valid && (m_exc != 6'h0));
      check("mdl_flush_MEM", flush_MEM, m_valid && m_ertn);
      if (m_valid) check("mdl_exc", exception_source, m_exc);
      if (exp_to_valid()) begin
        check("mdl_rf_wdata", rf_wdata, m_wdata());
        check("mdl_pc", PC, m_pc);
        check("mdl_rf_waddr", rf_waddr, m_waddr);
      end
`ifdef MEM_FWD_EN
      check("mdl_fwd_we", fwd_we, m_valid && m_we);
      check("mdl_fwd_ld_pend", fwd_load_pending, m_valid && m_mem && !m_ready());
      if (m_valid) check("mdl_fwd_waddr", fwd_waddr, m_waddr);
      if (exp_to_valid()) check("mdl_fwd_wdata", fwd_wdata, m_wdata());
`else
      check("mdl_fwd_we", fwd_we, 1'b0);
      check("mdl_fwd_ld_pend", fwd_load_pending, 1'b0);
      check("mdl_fwd_wdata", fwd_wdata, 32'h0);
`endif
      if (to_valid && from_allowin)
        $display("[TB] xfer pc=%h waddr=%0d wdata=%h exc=%b", PC, rf_waddr, rf_wdata, exception_source);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    from_valid          = 1'b0;
    from_allowin        = 1'b1;
    from_pc             = 32'h0;
    alu_result_EX       = 32'h0;
    rf_we_EX            = 1'b0;
    rf_waddr_EX         = 5'h0;
    res_from_mem_EX     = 1'b0;
    load_op_EX          = 5'h0;
    req_sent_EX         = 1'b0;
    exception_source_EX = 6'h0;
    ertn_flush_EX       = 1'b0;
    data_sram_data_ok   = 1'b0;
    ex_WB               = 1'b0;
    flush_WB            = 1'b0;
  endtask
  task automatic send(input logic [31:0] pc, input logic [31:0] alu, input logic we,
                      input logic [4:0] wa, input logic mem, input logic [4:0] op,
                      input logic req, input logic [5:0] exc, input logic ertn);
    from_valid          = 1'b1;
    from_pc             = pc;
    alu_result_EX       = alu;
    rf_we_EX            = we;
    rf_waddr_EX         = wa;
    res_from_mem_EX     = mem;
    load_op_EX          = op;
    req_sent_EX         = req;
    exception_source_EX = exc;
    ertn_flush_EX       = ertn;
  endtask

  logic [4:0]  lt_op   [6] = '{LDB, LDHU, LDH, LDBU, LDB, LDH};
  logic [31:0] lt_addr [6] = '{32'h1003, 32'h1002, 32'h1002, 32'h1001, 32'h1000, 32'h1000};
  logic [31:0] lt_data [6] = '{32'h80FF1234, 32'h80FF1234, 32'h80FF1234, 32'h80FF1234,
                               32'h80FF1234, 32'h0000F00D};
  logic [31:0] lt_exp  [6] = '{32'hFFFFFF80, 32'h000080FF, 32'hFFFF80FF, 32'h00000012,
                               32'h00000034, 32'hFFFFF00D};

  initial begin
    idle_inputs();
    data_sram_rdata = 32'h0;
    resetn = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    at_neg();
    check("rst_to_valid", to_valid, 1'b0);
    check("rst_to_allowin", to_allowin, 1'b1);
    check("rst_pc", PC, 32'h0);
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_rf_wdata", rf_wdata, 32'h0);
    check("rst_ex_MEM", ex_MEM, 1'b0);
    check("rst_flush_MEM", flush_MEM, 1'b0);
    check("rst_fwd_we", fwd_we, 1'b0);
    check("rst_fwd_waddr", fwd_waddr, 5'h0);
    check("rst_fwd_wdata", fwd_wdata, 32'h0);
    check("rst_fwd_ld_pend", fwd_load_pending, 1'b0);
    cyc();
    resetn = 1'b1;

    // ld_w, response three cycles after latch, bypassed the same cycle
    send(32'h100, 32'h1000, 1'b1, 5'd5, 1'b1, LDW, 1'b1, 6'h0, 1'b0);
    cyc();
    idle_inputs();
    at_neg();
    check("ldw_wait1", to_valid, 1'b0);
    cyc();
    at_neg();
    check("ldw_wait2", to_valid, 1'b0);
    cyc();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEADBEEF;
    at_neg();
    check("ldw_bypass_valid", to_valid, 1'b1);
    check("ldw_wdata", rf_wdata, 32'hDEADBEEF);
    check("ldw_pc", PC, 32'h100);
    cyc();
    data_sram_data_ok = 1'b0;
    at_neg();
    check("ldw_idle", to_valid, 1'b0);

    // sub-word extraction table
    for (int i = 0; i < 6; i++) begin
      send(32'h200 + 32'(4 * i), lt_addr[i], 1'b1, 5'(6 + i), 1'b1, lt_op[i], 1'b1, 6'h0, 1'b0);
      cyc();
      idle_inputs();
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = lt_data[i];
      at_neg();
      check("ext_valid", to_valid, 1'b1);
      check("ext_wdata", rf_wdata, lt_exp[i]);
      cyc();
      data_sram_data_ok = 1'b0;
    end

    // response while WB stalls: buffered, bus changes ignored
    send(32'h300, 32'h2000, 1'b1, 5'd8, 1'b1, LDW, 1'b1, 6'h0, 1'b0);
    cyc();
    idle_inputs();
    from_allowin      = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFEF00D;
    at_neg();
    check("stall_valid", to_valid, 1'b1);
    check("stall_allowin", to_allowin, 1'b0);
    check("stall_wdata0", rf_wdata, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      cyc();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'h12345678 + 32'(i);
      at_neg();
      check("stall_hold_valid", to_valid, 1'b1);
      check("stall_hold_wdata", rf_wdata, 32'hCAFEF00D);
    end
    cyc();
    from_allowin = 1'b1;
    at_neg();
    check("stall_release", to_allowin, 1'b1);
    check("stall_rel_wdata", rf_wdata, 32'hCAFEF00D);
    cyc();
    at_neg();
    check("stall_done", to_valid, 1'b0);

    // flush in WAIT orphans the outstanding response
    send(32'h400, 32'h3000, 1'b1, 5'd9, 1'b1, LDW, 1'b1, 6'h0, 1'b0);
    cyc();
    idle_inputs();
    ex_WB = 1'b1;
    at_neg();
    check("flush_to_valid", to_valid, 1'b0);
    check("flush_allowin", to_allowin, 1'b1);
    cyc();
    ex_WB = 1'b0;
    send(32'h404, 32'h3004, 1'b1, 5'd10, 1'b1, LDW, 1'b1, 6'h0, 1'b0);
    cyc();
    idle_inputs();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h11111111;
    at_neg();
    check("orphan_dropped", to_valid, 1'b0);
    cyc();
    data_sram_data_ok = 1'b0;
    at_neg();
    check("orphan_gap", to_valid, 1'b0);
    cyc();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h22222222;
    at_neg();
    check("young_valid", to_valid, 1'b1);
    check("young_wdata", rf_wdata, 32'h22222222);
    check("young_pc", PC, 32'h404);
    cyc();
    data_sram_data_ok = 1'b0;

    // no-request instructions: ALU op, SYS exception, ALE load, ertn
    send(32'h500, 32'h00000042, 1'b1, 5'd11, 1'b0, 5'h0, 1'b0, 6'h0, 1'b0);
    cyc();
    send(32'h504, 32'h1001, 1'b0, 5'd0, 1'b0, 5'h0, 1'b0, 6'b001000, 1'b0);
    at_neg();
    check("alu_valid", to_valid, 1'b1);
    check("alu_wdata", rf_wdata, 32'h42);
    check("alu_rf_we", rf_we, 1'b1);
    check("alu_ex_MEM", ex_MEM, 1'b0);
    cyc();
    send(32'h508, 32'h2002, 1'b1, 5'd12, 1'b1, LDW, 1'b0, 6'b000100, 1'b0);
    at_neg();
    check("sys_valid", to_valid, 1'b1);
    check("sys_ex_MEM", ex_MEM, 1'b1);
    check("sys_exc", exception_source, 6'b001000);
    check("sys_rf_we", rf_we, 1'b0);
    cyc();
    send(32'h50C, 32'h0, 1'b0, 5'd0, 1'b0, 5'h0, 1'b0, 6'h0, 1'b1);
    at_neg();
    check("ale_no_wait", to_valid, 1'b1);
    check("ale_exc", exception_source, 6'b000100);
    check("ale_ex_MEM", ex_MEM, 1'b1);
    cyc();
    idle_inputs();
    at_neg();
    check("ertn_flush_MEM", flush_MEM, 1'b1);
    check("ertn_valid", to_valid, 1'b1);
    cyc();

    // async reset mid-WAIT with an orphan outstanding
    send(32'h600, 32'h5000, 1'b1, 5'd13, 1'b1, LDW, 1'b1, 6'h0, 1'b0);
    cyc();
    idle_inputs();
    ex_WB = 1'b1;
    cyc();
    ex_WB = 1'b0;
    send(32'h604, 32'h5004, 1'b1, 5'd14, 1'b1, LDW, 1'b1, 6'h0, 1'b0);
    cyc();
    idle_inputs();
    at_neg();
    check("prerst_allowin", to_allowin, 1'b0);
    #1;
    resetn = 1'b0;
    #1;
    check("arst_to_valid", to_valid, 1'b0);
    check("arst_allowin", to_allowin, 1'b1);
    check("arst_pc", PC, 32'h0);
    check("arst_rf_we", rf_we, 1'b0);
    cyc();
    resetn = 1'b1;
    send(32'h608, 32'h5008, 1'b1, 5'd15, 1'b1, LDW, 1'b1, 6'h0, 1'b0);
    cyc();
    idle_inputs();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h33333333;
    at_neg();
    check("arst_orphan_clr", to_valid, 1'b1);
    check("arst_wdata", rf_wdata, 32'h33333333);
    cyc();
    data_sram_data_ok = 1'b0;

    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
